// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP datapath (divider, multiplier).
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} div_state_e;
endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 unpacker: classifies the operand and normalizes
// subnormals so the significand is always 1.f with a signed unbiased exponent.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]       x,
  output logic              sign,
  output fp_class_e         cls,
  output logic [10:0]       sig,
  output logic signed [6:0] exp
);
  logic [EXP_W-1:0]  e_fld;
  logic [FRAC_W-1:0] f_fld;
  logic [3:0]        lz;

  always_comb begin
    e_fld = x[14:10];
    f_fld = x[9:0];
    sign  = x[15];
    // distance from the highest set fraction bit to the implicit-one position
    lz = 4'd0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (f_fld[i]) lz = 4'(FRAC_W - i);
    end
    cls = NORM;
    sig = {1'b1, f_fld};
    exp = $signed({2'b00, e_fld}) - $signed(7'(BIAS));
    if (e_fld == 5'd0) begin
      if (f_fld == '0) begin
        cls = ZERO;
        sig = '0;
        exp = '0;
      end else begin
        cls = SUB;
        sig = {1'b0, f_fld} << lz;
        exp = -7'sd14 - $signed({3'b000, lz});
      end
    end else if (e_fld == 5'h1F) begin
      cls = (f_fld == '0) ? INF : NAN;
    end
  end
endmodule

// File: rtl/fp16_div_seq.sv
// Sequential binary16 divider: restoring mantissa division, one quotient bit
// per cycle, fixed 16-cycle latency with a start/done handshake.
//
//   state   | meaning
//   S_IDLE  | waiting for start, operands captured on acceptance
//   S_PREP  | unpack operands, resolve special cases, seed divider
//   S_DIV   | 13 restoring iterations, counter runs 12 -> 0
//   S_ROUND | normalize, denormalize, round-to-nearest-even, register result
//   S_DONE  | done pulse, result/dz valid
module fp16_div_seq
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        dz
);
  div_state_e        state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [6:0] exp_q, exp_d;
  logic [11:0]       rem_q, rem_d;
  logic [10:0]       mb_q, mb_d;
  logic [12:0]       quo_q, quo_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              spec_q, spec_d;
  logic [15:0]       spec_res_q, spec_res_d;
  logic              spec_dz_q, spec_dz_d;
  logic [15:0]       result_q, result_d;
  logic              dz_q, dz_d;

  logic              sa, sb;
  fp_class_e         ca, cb;
  logic [10:0]       ma, mb;
  logic signed [6:0] ea, eb;

  fp16_unpack u_unpack_a (.x(a_q), .sign(sa), .cls(ca), .sig(ma), .exp(ea));
  fp16_unpack u_unpack_b (.x(b_q), .sign(sb), .cls(cb), .sig(mb), .exp(eb));

  logic              div_ge;
  logic [11:0]       div_diff;
  logic [10:0]       r_sig;
  logic              r_g, r_st, inc;
  logic signed [6:0] r_exp;
  logic [4:0]        r_bexp;
  logic [5:0]        shamt;
  logic [23:0]       w, w_sh;
  logic [14:0]       rnd_mag;
  logic [15:0]       rnd_res;

  always_comb begin
    div_ge   = rem_q >= {1'b0, mb_q};
    div_diff = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  always_comb begin
    if (quo_q[12]) begin
      r_sig = quo_q[12:2];
      r_g   = quo_q[1];
      r_st  = quo_q[0] | (|rem_q);
      r_exp = exp_q;
    end else begin
      r_sig = quo_q[11:1];
      r_g   = quo_q[0];
      r_st  = |rem_q;
      r_exp = exp_q - 7'sd1;
    end
    r_bexp = r_exp[4:0];
    shamt  = '0;
    w      = {r_sig, r_g, 12'b0};
    w_sh   = w;
    // underflow: any bit that falls below the guard position, or off the end, is sticky
    if (r_exp <= 7'sd0) begin
      shamt  = 6'(7'sd1 - r_exp);
      w_sh   = w >> shamt;
      r_sig  = w_sh[23:13];
      r_g    = w_sh[12];
      r_st   = r_st | (|w_sh[11:0]) | ((w_sh << shamt) != w);
      r_bexp = 5'd0;
    end
    inc     = r_g & (r_st | r_sig[0]);
    rnd_mag = {r_bexp, r_sig[9:0]} + 15'(inc);
    if (r_exp >= 7'sd31 || rnd_mag[14:10] == 5'h1F) rnd_res = {sign_q, POS_INF[14:0]};
    else                                            rnd_res = {sign_q, rnd_mag};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    rem_d      = rem_q;
    mb_d       = mb_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_dz_d  = spec_dz_q;
    result_d   = result_q;
    dz_d       = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d    = sa ^ sb;
        exp_d     = ea - eb + $signed(7'(BIAS));
        rem_d     = {1'b0, ma};
        mb_d      = mb;
        quo_d     = '0;
        cnt_d     = 4'd12;
        spec_d    = 1'b1;
        spec_dz_d = 1'b0;
        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
          spec_res_d = QNAN;
        else if (ca == INF)  spec_res_d = {sa ^ sb, POS_INF[14:0]};
        else if (cb == INF)  spec_res_d = {sa ^ sb, 15'd0};
        else if (ca == ZERO) spec_res_d = {sa ^ sb, 15'd0};
        else if (cb == ZERO) begin
          spec_res_d = {sa ^ sb, POS_INF[14:0]};
          spec_dz_d  = 1'b1;
        end else begin
          spec_d     = 1'b0;
          spec_res_d = '0;
        end
        state_d = S_DIV;
      end
      S_DIV: begin
        quo_d = {quo_q[11:0], div_ge};
        rem_d = div_diff << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = spec_q ? spec_res_q : rnd_res;
        dz_d     = spec_q & spec_dz_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      mb_q       <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_dz_q  <= 1'b0;
      result_q   <= '0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      mb_q       <= mb_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_dz_q  <= spec_dz_d;
      result_q   <= result_d;
      dz_q       <= dz_d;
    end
  end

  assign busy   = (state_q == S_PREP) || (state_q == S_DIV) || (state_q == S_ROUND);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign dz     = dz_q;
endmodule
